// File: rtl/div_ctrl_pkg.sv
// Shared RV32M divide definitions: func3/opcode/func7 codes, FSM state encodings
// and small sign helpers used by the divider control block.
package div_ctrl_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_M      = 7'b0000001;

  localparam logic [5:0] ITER_COUNT = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  function automatic logic is_m_ext(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == INST_TYPE_R_M) && (funct7 == FUNCT7_M);
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == INST_DIV[1:0]) || (op == INST_REM[1:0]);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == INST_REM[1:0]) || (op == INST_REMU[1:0]);
  endfunction

  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] value);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [31:0] rem_in,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        quot_bit
);

  logic [32:0] rem_shift;
  logic [33:0] diff;

  always_comb begin
    rem_shift = {rem_in, dividend_bit};
    diff      = {1'b0, rem_shift} - {2'b00, divisor};
    quot_bit  = ~diff[33];
    rem_out   = quot_bit ? diff[31:0] : rem_shift[31:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// RV32M multi-cycle divider control: FSM, iteration counter, sign fix-up and handshake.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_wen_o,
  output logic        hold_flag_o
);

  div_state_e  state, state_next;
  logic [5:0]  count;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] quot_q, rem_q, divisor_q;
  logic        quot_neg_q, rem_neg_q, div_zero_q;

  logic        op_signed, dvd_neg, dvs_neg, div_zero, accept, early_out, last_iter;
  logic [31:0] dvd_mag, dvs_mag;
  logic [31:0] step_rem;
  logic        step_bit;
  logic [31:0] quot_fix, rem_fix, final_result;

  assign op_signed = is_signed_op(op_i);
  assign dvd_neg   = op_signed & dividend_i[31];
  assign dvs_neg   = op_signed & divisor_i[31];
  assign dvd_mag   = cond_neg(dvd_neg, dividend_i);
  assign dvs_mag   = cond_neg(dvs_neg, divisor_i);
  assign div_zero  = (divisor_i == 32'd0);
  assign accept    = (state == S_IDLE) & start_i & ~flush_i;
  assign last_iter = (count <= 6'd1);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = div_zero |
                     (op_signed & (dividend_i == 32'h8000_0000) & (divisor_i == 32'hFFFF_FFFF));
`else
  assign early_out = 1'b0;
`endif

  div_step u_step (
    .rem_in       (rem_q),
    .dividend_bit (quot_q[31]),
    .divisor      (divisor_q),
    .rem_out      (step_rem),
    .quot_bit     (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = early_out ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (flush_i)        state_next = S_IDLE;
        else if (last_iter) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // quot_q starts as the dividend magnitude and fills with quotient bits from the right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 6'd0;
      op_q       <= 2'd0;
      rd_q       <= 5'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      divisor_q  <= 32'd0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      count      <= ITER_COUNT;
      op_q       <= op_i;
      rd_q       <= rd_addr_i;
      quot_q     <= dvd_mag;
      rem_q      <= (early_out & div_zero) ? dvd_mag : 32'd0;
      divisor_q  <= dvs_mag;
      quot_neg_q <= dvd_neg ^ dvs_neg;
      rem_neg_q  <= dvd_neg;
      div_zero_q <= div_zero;
    end else if ((state == S_CALC) && !flush_i) begin
      count  <= (count != 6'd0) ? count - 6'd1 : 6'd0;
      quot_q <= {quot_q[30:0], step_bit};
      rem_q  <= step_rem;
    end
  end

  // Divide-by-zero quotient is all ones regardless of operand signs
  always_comb begin
    quot_fix     = div_zero_q ? 32'hFFFF_FFFF : cond_neg(quot_neg_q, quot_q);
    rem_fix      = cond_neg(rem_neg_q, rem_q);
    final_result = is_rem_op(op_q) ? rem_fix : quot_fix;
  end

  always_comb begin
    busy_o      = (state != S_IDLE);
    ready_o     = (state == S_DONE) & ~flush_i;
    reg_wen_o   = ready_o;
    result_o    = ready_o ? final_result : 32'd0;
    rd_addr_o   = ready_o ? rd_q : 5'd0;
    hold_flag_o = (start_i & (state == S_IDLE)) | (state == S_CALC);
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: results, latency, hold, flush and reset.
// Expected latency of zero-divisor / overflow cases follows DIV_EARLY_OUT_EN.
module tb_div_ctrl;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 0;
`else
  localparam int EARLY_LAT = 32;
`endif

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;
  logic        hold_flag_o;

  int tests_run    = 0;
  int tests_failed = 0;

  div_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .rd_addr_o   (rd_addr_o),
    .reg_wen_o   (reg_wen_o),
    .hold_flag_o (hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {23'd0, busy_o, ready_o, reg_wen_o, hold_flag_o, rd_addr_o, result_o};
  endfunction

  // Call just after a negedge; returns #1 after the accepting edge E0 with start dropped
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] exp_res, input int exp_lat, input int inject);
    int idx, hold_bad, zero_bad;
    logic seen;
    idx = 0; hold_bad = 0; zero_bad = 0; seen = 1'b0;
    launch(op, a, b, rd);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
      if (!hold_flag_o) hold_bad++;
      if (result_o != 32'd0 || rd_addr_o != 5'd0 || reg_wen_o) zero_bad++;
      if (n == inject) begin
        start_i    = 1'b1;
        op_i       = OP_DIVU;
        dividend_i = 32'd9;
        divisor_i  = 32'd3;
        rd_addr_i  = 5'd9;
      end else if (n == inject + 1) begin
        start_i = 1'b0;
      end
      idx++;
    end
    start_i = 1'b0;
    checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
    checkOutput({tag, "_result"}, 64'(result_o), 64'(exp_res));
    checkOutput({tag, "_rd"}, 64'(rd_addr_o), 64'(rd));
    checkOutput({tag, "_wen"}, 64'(reg_wen_o), 64'd1);
    checkOutput({tag, "_lat"}, 64'(idx), 64'(exp_lat));
    checkOutput({tag, "_hold_done"}, 64'(hold_flag_o), 64'd0);
    checkOutput({tag, "_hold_calc"}, 64'(hold_bad), 64'd0);
    checkOutput({tag, "_zero_idle"}, 64'(zero_bad), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_after"}, all_outs(), 64'd0);
  endtask

  initial begin
    int ready_cnt;
    rst_n = 1'b0; start_i = 1'b0; op_i = 2'd0; dividend_i = 32'd0;
    divisor_i = 32'd0; rd_addr_i = 5'd0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_during", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_after", all_outs(), 64'd0);

    applyStimulus("divu_100_7",  OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         32, -1);
    applyStimulus("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  32, -1);
    applyStimulus("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  32, -1);
    applyStimulus("div_20_m3",   OP_DIV,  32'd20,         32'hFFFF_FFFD,  5'd3,  32'hFFFF_FFFA,  32, -1);
    applyStimulus("rem_20_m3",   OP_REM,  32'd20,         32'hFFFF_FFFD,  5'd4,  32'd2,          32, -1);
    applyStimulus("remu_max_16", OP_REMU, 32'hFFFF_FFFF,  32'd16,         5'd6,  32'd15,         32, -1);
    applyStimulus("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd7,  32'hFFFF_FFFF,  32, -1);
    applyStimulus("divu_ovf_op", OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          32, -1);
    applyStimulus("remu_7_0",    OP_REMU, 32'd7,          32'd0,          5'd10, 32'd7,          EARLY_LAT, -1);
    applyStimulus("divu_5_0",    OP_DIVU, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  EARLY_LAT, -1);
    applyStimulus("div_m5_0",    OP_DIV,  32'hFFFF_FFFB,  32'd0,          5'd12, 32'hFFFF_FFFF,  EARLY_LAT, -1);
    applyStimulus("rem_m5_0",    OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd13, 32'hFFFF_FFFB,  EARLY_LAT, -1);
    applyStimulus("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h8000_0000,  EARLY_LAT, -1);
    applyStimulus("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          EARLY_LAT, -1);
    applyStimulus("start_ignored", OP_DIVU, 32'd100,      32'd7,          5'd5,  32'd14,         32, 4);

    // Flush mid-CALC at E10..E11, then a fresh op accepted at E12
    launch(OP_DIVU, 32'd1000, 32'd10, 5'd3);
    ready_cnt = 0;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      if (ready_o) ready_cnt++;
      if (n == 10) flush_i = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush_calc_noready", 64'(ready_cnt), 64'd0);
    checkOutput("flush_calc_idle", all_outs(), 64'd0);
    applyStimulus("after_flush", OP_DIV, 32'd1000, 32'hFFFF_FFF6, 5'd7, 32'hFFFF_FF9C, 32, -1);

    launch(OP_DIVU, 32'd50, 32'd5, 5'd2);
    for (int n = 0; n < 32; n++) @(negedge clk);
    @(negedge clk);
    checkOutput("done_pre_flush_ready", 64'(ready_o), 64'd1);
    flush_i = 1'b1;
    #1;
    checkOutput("done_flush_outs", {32'd0, 27'd0, ready_o, reg_wen_o, 3'd0} | 64'(result_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("done_flush_idle", 64'(busy_o), 64'd0);

    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU;
    dividend_i = 32'd8; divisor_i = 32'd2; rd_addr_i = 5'd4;
    @(posedge clk);
    #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_start_idle", all_outs(), 64'd0);

    // Reset in the middle of CALC must abort without any result pulse
    launch(OP_DIVU, 32'd100, 32'd7, 5'd5);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready_o || busy_o) ready_cnt++;
    end
    checkOutput("rst_mid_noready", 64'(ready_cnt), 64'd0);
    checkOutput("rst_mid_idle", all_outs(), 64'd0);
    applyStimulus("after_reset", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 32, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
